// File: rtl/controller_ram_master_pkg.sv
// Shared types and constants for the controller RAM master engine.
// Holds the FSM state enum, mode encoding and LFSR pattern constants.
package controller_ram_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_VERIFY,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic MODE_FILL   = 1'b0;
    localparam logic MODE_VERIFY = 1'b1;

    localparam logic [31:0] LFSR_POLY         = 32'h8020_0003;
    localparam logic [31:0] LFSR_NONZERO_SEED = 32'h0000_0001;

    // Galois LFSR step: shift right, fold the polynomial back in when a one falls out.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
    endfunction

endpackage

// File: rtl/controller_ram_pattern_gen.sv
// Word pattern generator shared by the write path and the expected-data path.
// CONTROLLER_RAM_MASTER_LFSR_EN selects a 32-bit Galois LFSR; otherwise seed + i.
module controller_ram_pattern_gen
    import controller_ram_master_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [DATA_W-1:0] seed,
    input  logic              advance,
    output logic [DATA_W-1:0] pattern
);

`ifdef CONTROLLER_RAM_MASTER_LFSR_EN
    // An all-zero LFSR would lock up, so a zero seed is replaced.
    logic [DATA_W-1:0] load_value;
    logic [DATA_W-1:0] next_value;

    assign load_value = (seed == '0) ? DATA_W'(LFSR_NONZERO_SEED) : seed;
    assign next_value = DATA_W'(lfsr_step(32'(pattern)));
`else
    logic [DATA_W-1:0] load_value;
    logic [DATA_W-1:0] next_value;

    assign load_value = seed;
    assign next_value = pattern + 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pattern <= '0;
        end else if (load) begin
            pattern <= load_value;
        end else if (advance) begin
            pattern <= next_value;
        end
    end

endmodule

// File: rtl/controller_ram_master.sv
// Avalon-MM host that fills a RAM block with a pattern or reads it back and verifies it.
// Build option: CONTROLLER_RAM_MASTER_LFSR_EN selects the LFSR pattern in controller_ram_pattern_gen.
module controller_ram_master
    import controller_ram_master_pkg::*;
#(
    parameter int DEPTH        = 10000,
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                mode,
    input  logic [ADDR_W-1:0]   base,
    input  logic [ADDR_W-1:0]   count,
    input  logic [DATA_W-1:0]   seed,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   err_count,
    output logic                first_err_valid,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic [ADDR_W-1:0]   avm_address,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic                avm_chipselect,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic                avm_clken,
    input  logic [DATA_W-1:0]   avm_readdata
);

    state_t            state;
    logic [ADDR_W-1:0] remaining;
    logic [1:0]        drain_cnt;
    logic [DATA_W-1:0] pattern;
    logic              accept;
    logic              pat_load;
    logic              pat_advance;

    logic [READ_LATENCY-1:0] rd_valid;
    logic [ADDR_W-1:0]       rd_addr [READ_LATENCY];
    logic [DATA_W-1:0]       rd_exp  [READ_LATENCY];
    logic                    mismatch;

    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + 1'b1;
    endfunction

    assign avm_byteenable = '1;
    assign avm_clken      = reset_n;
    assign avm_writedata  = pattern;

    assign accept      = (state == ST_IDLE) && start;
    assign pat_load    = accept;
    assign pat_advance = ((state == ST_FILL) || (state == ST_VERIFY)) && (remaining != '0);

    controller_ram_pattern_gen #(
        .DATA_W (DATA_W)
    ) u_pattern_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (pat_load),
        .seed    (seed),
        .advance (pat_advance),
        .pattern (pattern)
    );

    // `remaining` counts words still to issue after the one on the bus now.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            avm_chipselect <= 1'b0;
            avm_write      <= 1'b0;
            avm_address    <= '0;
            remaining      <= '0;
            drain_cnt      <= '0;
        end else begin
            // NOTE: every register here is updated with <= so all branches see pre-edge values.
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy        <= 1'b1;
                        avm_address <= base;
                        if (count == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            remaining      <= count - 1'b1;
                            avm_chipselect <= 1'b1;
                            avm_write      <= (mode == MODE_FILL);
                            state          <= (mode == MODE_FILL) ? ST_FILL : ST_VERIFY;
                        end
                    end
                end
                ST_FILL, ST_VERIFY: begin
                    if (remaining == '0) begin
                        avm_chipselect <= 1'b0;
                        avm_write      <= 1'b0;
                        if (state == ST_FILL) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= ST_DRAIN;
                            drain_cnt <= 2'(READ_LATENCY - 1);
                        end
                    end else begin
                        avm_address <= addr_inc(avm_address);
                        remaining   <= remaining - 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Only the valid bits of the read-latency delay line need a reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid <= '0;
        end else begin
            rd_valid[0] <= avm_chipselect && !avm_write;
            for (int i = 1; i < READ_LATENCY; i++) begin
                rd_valid[i] <= rd_valid[i-1];
            end
        end
    end

    // NOTE: address/expected-data stages carry no reset; they are ignored until their valid bit is set.
    always_ff @(posedge clk) begin
        rd_addr[0] <= avm_address;
        rd_exp[0]  <= pattern;
        for (int i = 1; i < READ_LATENCY; i++) begin
            rd_addr[i] <= rd_addr[i-1];
            rd_exp[i]  <= rd_exp[i-1];
        end
    end

    assign mismatch = rd_valid[READ_LATENCY-1] && (avm_readdata != rd_exp[READ_LATENCY-1]);

    // Results clear only on an accepted VERIFY start and otherwise hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
        end else if (accept && (mode == MODE_VERIFY)) begin
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
        end else if (mismatch) begin
            if (err_count != '1) begin
                err_count <= err_count + 1'b1;
            end
            if (!first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_addr  <= rd_addr[READ_LATENCY-1];
            end
        end
    end

endmodule

// File: tb/tb_controller_ram_master.sv
// Self-checking bench for controller_ram_master: RAM model, randomized commands and a
// word-level reference model of pattern, addressing, timing and verify results.
module tb_controller_ram_master;

    localparam int DEPTH  = 10000;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int RL     = 1;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                start = 1'b0;
    logic                mode = 1'b0;
    logic [ADDR_W-1:0]   base = '0;
    logic [ADDR_W-1:0]   count = '0;
    logic [DATA_W-1:0]   seed = '0;
    logic                busy;
    logic                done;
    logic [ADDR_W-1:0]   err_count;
    logic                first_err_valid;
    logic [ADDR_W-1:0]   first_err_addr;
    logic [ADDR_W-1:0]   avm_address;
    logic [DATA_W/8-1:0] avm_byteenable;
    logic                avm_chipselect;
    logic                avm_write;
    logic [DATA_W-1:0]   avm_writedata;
    logic                avm_clken;
    logic [DATA_W-1:0]   avm_readdata;

    always #5 clk = ~clk;

    controller_ram_master #(
        .DEPTH        (DEPTH),
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .READ_LATENCY (RL)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .mode            (mode),
        .base            (base),
        .count           (count),
        .seed            (seed),
        .busy            (busy),
        .done            (done),
        .err_count       (err_count),
        .first_err_valid (first_err_valid),
        .first_err_addr  (first_err_addr),
        .avm_address     (avm_address),
        .avm_byteenable  (avm_byteenable),
        .avm_chipselect  (avm_chipselect),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_clken       (avm_clken),
        .avm_readdata    (avm_readdata)
    );

    // RAM slave model with a backdoor write port used for corruption.
    bit [DATA_W-1:0]   mem     [DEPTH];
    bit [DATA_W-1:0]   rd_pipe [RL];
    logic              bd_valid = 1'b0;
    logic [ADDR_W-1:0] bd_addr  = '0;
    logic [DATA_W-1:0] bd_data  = '0;

    always @(posedge clk) begin
        if (avm_chipselect && avm_write) mem[avm_address] <= avm_writedata;
        else if (bd_valid)               mem[bd_addr] <= bd_data;
        if (avm_chipselect && !avm_write) rd_pipe[0] <= mem[avm_address];
        for (int j = 1; j < RL; j++) rd_pipe[j] <= rd_pipe[j-1];
    end
    assign avm_readdata = rd_pipe[RL-1];

    int n_cmp = 0;
    int n_mis = 0;

    int          model_err = 0;
    bit          model_first_valid = 1'b0;
    int          model_first_addr = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] pat(input logic [DATA_W-1:0] s, input int i);
`ifdef CONTROLLER_RAM_MASTER_LFSR_EN
        logic [31:0] v;
        v = (s == 0) ? 32'h1 : s;
        for (int k = 0; k < i; k++) v = v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
        return v;
`else
        return s + DATA_W'(i);
`endif
    endfunction

    task automatic backdoor(input int a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        bd_addr  = ADDR_W'(a);
        bd_data  = d;
        bd_valid = 1'b1;
        @(negedge clk);
        bd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic m, input int b, input int n, input logic [DATA_W-1:0] s,
                           input bit poke_busy);
        int  k, acc, done_cyc, exp_cyc, a, e, fa;
        bit  busy_ok, stray;
        if (m == 1'b1) begin
            e = 0;
            fa = 0;
            for (int i = 0; i < n; i++) begin
                a = (b + i) % DEPTH;
                if (mem[a] != pat(s, i)) begin
                    if (e == 0) fa = a;
                    if (e < (1 << ADDR_W) - 1) e++;
                end
            end
            model_err = e;
            model_first_valid = (e > 0);
            model_first_addr = fa;
        end
        exp_cyc = (n == 0) ? 1 : ((m == 1'b0) ? n + 1 : n + 1 + RL);

        @(negedge clk);
        start = 1'b1;
        mode  = m;
        base  = ADDR_W'(b);
        count = ADDR_W'(n);
        seed  = s;
        @(posedge clk);
        #1 start = 1'b0;
        k = 1; acc = 0; done_cyc = 0; busy_ok = 1'b1;
        while (k <= n + RL + 6) begin
            if (!busy) busy_ok = 1'b0;
            if (avm_chipselect) begin
                check("acc_addr", avm_address, (b + acc) % DEPTH);
                check("acc_write", avm_write, (m == 1'b0));
                check("acc_cycle", k, acc + 1);
                if (avm_write) check("acc_data", avm_writedata, pat(s, acc));
                acc++;
            end
            if (done) begin
                done_cyc = k;
                break;
            end
            if (poke_busy && k == 3) begin
                start = 1'b1;
                mode  = ~m;
                base  = ADDR_W'(7);
                count = ADDR_W'(5);
                seed  = ~s;
            end
            @(posedge clk);
            #1 start = 1'b0;
            k++;
        end
        if (done_cyc == 0) begin
            check("done_timeout", 0, 1);
        end else begin
            check("done_cycle", done_cyc, exp_cyc);
            check("access_count", acc, n);
            check("busy_during", busy_ok, 1);
            @(posedge clk);
            #1;
            check("done_pulse", done, 0);
            check("busy_after", busy, 0);
            check("err_count", err_count, model_err);
            check("first_err_valid", first_err_valid, model_first_valid);
            check("first_err_addr", first_err_addr, model_first_addr);
            if (m == 1'b0) begin
                for (int i = 0; i < n; i++) check("fill_mem", mem[(b + i) % DEPTH], pat(s, i));
            end
            if (poke_busy) begin
                stray = 1'b0;
                repeat (4) begin
                    @(posedge clk);
                    #1 if (avm_chipselect || busy) stray = 1'b1;
                end
                check("start_while_busy_ignored", stray, 0);
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err_count"}, err_count, 0);
        check({tag, "_first_valid"}, first_err_valid, 0);
        check({tag, "_first_addr"}, first_err_addr, 0);
        check({tag, "_cs"}, avm_chipselect, 0);
        check({tag, "_write"}, avm_write, 0);
        check({tag, "_addr"}, avm_address, 0);
        check({tag, "_wdata"}, avm_writedata, 0);
        check({tag, "_clken"}, avm_clken, 0);
        check({tag, "_be"}, avm_byteenable, 4'hF);
    endtask

    task automatic reset_mid_fill();
        bit saw_done;
        @(negedge clk);
        start = 1'b1; mode = 1'b0; base = ADDR_W'(200); count = ADDR_W'(16); seed = 32'hCAFE_0000;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("pre_reset_cs", avm_chipselect, 1);
        check("pre_reset_addr", avm_address, 202);
        #2 reset_n = 1'b0;
        #1;
        check_reset_values("mid_reset");
        saw_done = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1 if (done || avm_chipselect) saw_done = 1'b1;
        end
        check("no_done_in_reset", saw_done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        model_err = 0;
        model_first_valid = 1'b0;
        model_first_addr = 0;
        @(posedge clk);
        #1 check("post_reset_clken", avm_clken, 1);
    endtask

    initial begin
        logic [DATA_W-1:0] s;
        int b, n, ci;
        repeat (3) @(posedge clk);
        #1 check_reset_values("reset");
        @(negedge clk);
        reset_n = 1'b1;

        run_cmd(1'b0, 0, 16, 32'h0000_1000, 1'b0);
        run_cmd(1'b1, 0, 16, 32'h0000_1000, 1'b0);
        run_cmd(1'b0, 9998, 4, $urandom, 1'b0);

        run_cmd(1'b0, 0, 16, 32'h1234_5678, 1'b0);
        backdoor(5, mem[5] ^ 32'h0000_0100);
        backdoor(9, mem[9] ^ 32'h8000_0000);
        run_cmd(1'b1, 0, 16, 32'h1234_5678, 1'b0);
        check("corrupt_err_count", err_count, 2);
        check("corrupt_first_addr", first_err_addr, 5);

        run_cmd(1'b0, 50, 0, 32'h1, 1'b0);
        run_cmd(1'b1, 50, 0, 32'h1, 1'b0);
        run_cmd(1'b0, 300, 12, 32'hA5A5_0000, 1'b1);
        run_cmd(1'b1, 300, 12, 32'hA5A5_0000, 1'b1);

        reset_mid_fill();
        run_cmd(1'b0, 200, 16, 32'hCAFE_0000, 1'b0);
        run_cmd(1'b1, 200, 16, 32'hCAFE_0000, 1'b0);

        for (int it = 0; it < 20; it++) begin
            s = $urandom;
            b = $urandom_range(0, DEPTH - 1);
            n = $urandom_range(0, 40);
            run_cmd(1'b0, b, n, s, 1'b0);
            if (n > 0) begin
                repeat ($urandom_range(0, 2)) begin
                    ci = (b + $urandom_range(0, n - 1)) % DEPTH;
                    backdoor(ci, mem[ci] ^ ($urandom | 32'h1));
                end
            end
            if ($urandom_range(0, 3) == 0) s = s ^ 32'h0000_0010;
            run_cmd(1'b1, b, n, s, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/controller_ram_master.md
# controller_ram_master

Avalon-MM host engine that drives the controller's on-chip RAM slave port (s1/s2) to fill a block of words with a generated pattern or to read a block back and verify it. It sits between the controller's test/maintenance logic and the RAM slave. It issues one access per cycle with no wait states and uses the RAM's fixed read latency. It is the initiator side of the RAM's single-port interface and is used for power-on scrub, memory test and pattern preload.

## Interface
- DEPTH, 10000: RAM words; addresses wrap modulo DEPTH.
- ADDR_W, 14: word-address width.
- DATA_W, 32: data width; byteenable width is DATA_W/8.
- READ_LATENCY, 1: cycles from read address to valid readdata; supported range 1–3.

- clk  in  1  system clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  command strobe; sampled only in IDLE.
- mode  in  1  0 = FILL (write), 1 = VERIFY (read and compare).
- base  in  ADDR_W  first word address; must be < DEPTH.
- count  in  ADDR_W  number of words; 0 is legal.
- seed  in  DATA_W  pattern seed.
- busy  out  1  high from the cycle after an accepted start through the done cycle.
- done  out  1  one-cycle completion pulse.
- err_count  out  ADDR_W  mismatches in the last VERIFY; saturates at all-ones.
- first_err_valid  out  1  at least one mismatch was seen.
- first_err_addr  out  ADDR_W  address of the first mismatch.
- avm_address  out  ADDR_W  RAM word address.
- avm_byteenable  out  DATA_W/8  always all-ones.
- avm_chipselect  out  1  access strobe.
- avm_write  out  1  write qualifier.
- avm_writedata  out  DATA_W  write data.
- avm_clken  out  1  RAM clock enable; 1 whenever reset_n is high.
- avm_readdata  in  DATA_W  RAM read data.

## Operation
- States: IDLE, FILL, VERIFY, DRAIN, DONE.
- IDLE:
  - start=1 latches base, count, mode and seed.
  - Loads the pattern generator and clears err_count, first_err_valid and first_err_addr; these results are not cleared for FILL.
  - count=0 goes directly to DONE with no bus access.
  - Otherwise goes to FILL or VERIFY.
- FILL: each cycle asserts chipselect=1, write=1, address=cur and writedata=pattern. It then advances the address and pattern. After word count it goes to DONE.
- VERIFY: each cycle asserts chipselect=1, write=0 and address=cur.
  - The expected pattern and address are delayed READ_LATENCY cycles and compared with avm_readdata.
  - After the last issue the FSM goes to DRAIN.
- DRAIN: issues no accesses and waits READ_LATENCY cycles for outstanding compares, then goes to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Address increment: cur = (cur == DEPTH-1) ? 0 : cur+1.
- Mismatch handling: err_count increments and saturates. The first mismatch sets first_err_valid and records first_err_addr; later mismatches do not change them.
- start while busy is ignored, with no queueing.
- Results hold until the next accepted VERIFY start.

## Timing
- Reset values: busy=0, done=0, err_count=0, first_err_valid=0, first_err_addr=0, avm_chipselect=0, avm_write=0, avm_address=0, avm_writedata=0, avm_clken=0, avm_byteenable=all-ones.
- Bus outputs are registered.
- Start accepted in cycle 0: accesses occur in cycles 1..N.
  - FILL: done in cycle N+1.
  - VERIFY: done in cycle N+1+READ_LATENCY.
  - count=0: done in cycle 1.
- Throughput is one word per cycle; no waitrequest exists.
- Reset mid-operation: avm_chipselect and avm_write drop asynchronously. All state returns to reset values and no done pulse is produced.

## Configuration
- CONTROLLER_RAM_MASTER_LFSR_EN defined:
  - The pattern is a 32-bit Galois LFSR with polynomial 32'h80200003 (mask applied after a right shift when the LSB is 1).
  - It is seeded with seed; a seed of 0 is forced to 1.
  - The LFSR advances once per word.
- Macro undefined: the pattern for word i is seed + i, modulo 2^DATA_W.

## Structure
- Package controller_ram_master_pkg holds:
  - the state enum;
  - the mode encoding (MODE_FILL=0, MODE_VERIFY=1);
  - the LFSR polynomial constant and the forced nonzero seed value.
- Sub-module controller_ram_pattern_gen: ports load, seed, advance and pattern. It contains the macro-selected generator. One instance supplies both the write data and the expected data.
- The read-latency delay line and the comparator live in the top-level module.

## Test plan
- FILL with base=0, count=16, seed=0x1000 (macro off) → words 0..15 = 0x1000..0x100F; done in cycle 17.
- VERIFY of the same region after FILL → err_count=0, first_err_valid=0; done in cycle 18 with READ_LATENCY=1.
- FILL with base=9998, count=4 → writes to 9998, 9999, 0, 1 in that order.
- FILL, then a backdoor corruption of word 5 and word 9, then VERIFY with base=0, count=16 → err_count=2, first_err_addr=5.
- start with count=0 → done in cycle 1, avm_chipselect never high; start pulsed while busy → ignored.
- Drop reset_n during word 3 of a 16-word FILL → chipselect drops immediately, no done, all outputs at reset values; a new start afterwards runs normally.
